// File: rtl/mem_arbiter_rr_if.sv
// rtl/mem_arbiter_rr_if.sv - requester and memory-side signal bundle for mem_arbiter_rr
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int BLK_SIZE  = 128
);
  localparam int GID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            req_valid_i;
  logic [NUM_PORTS*ADDR_W-1:0]     req_addr_i;
  logic [NUM_PORTS-1:0]            req_rw_i;
  logic [NUM_PORTS*BLK_SIZE-1:0]   req_wdata_i;
  logic [NUM_PORTS*BLK_SIZE/8-1:0] req_wstrb_i;
  logic [NUM_PORTS-1:0]            req_ready_o;
  logic [NUM_PORTS-1:0]            res_valid_o;
  logic [BLK_SIZE-1:0]             res_data_o;

  logic                            mem_req_valid_o;
  logic                            mem_req_ready_i;
  logic [ADDR_W-1:0]               mem_req_addr_o;
  logic [BLK_SIZE-1:0]             mem_req_data_o;
  logic [BLK_SIZE/8-1:0]           mem_req_wstrb_o;
  logic                            mem_res_valid_i;
  logic [BLK_SIZE-1:0]             mem_rdata_i;

  logic [GID_W-1:0]                grant_id_o;
  logic                            busy_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_rw_i, req_wdata_i, req_wstrb_i,
    input  mem_req_ready_i, mem_res_valid_i, mem_rdata_i,
    output req_ready_o, res_valid_o, res_data_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_data_o, mem_req_wstrb_o,
    output grant_id_o, busy_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_rw_i, req_wdata_i, req_wstrb_i,
    output mem_req_ready_i, mem_res_valid_i, mem_rdata_i,
    input  req_ready_o, res_valid_o, res_data_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_data_o, mem_req_wstrb_o,
    input  grant_id_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-port round-robin / fixed-priority memory arbiter
// One transaction outstanding; the request is latched on accept and the grant held until the response.
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int BLK_SIZE  = 128,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mem_arbiter_rr_if.slave     bus
);
  localparam int GID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int STRB_W = BLK_SIZE / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [GID_W-1:0]      rr_ptr_q;
  logic [GID_W-1:0]      grant_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [BLK_SIZE-1:0]   wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  win_found;
  logic [GID_W-1:0]      win_id;
  logic [GID_W-1:0]      scan_base;
  logic [GID_W-1:0]      ptr_next;
  logic [NUM_PORTS-1:0]  req_ready;
  logic [NUM_PORTS-1:0]  res_valid;
  logic                  mem_req_valid;
  logic                  accept;
  logic                  done;

  // Port index reached after stepping off positions from base, wrapping at NUM_PORTS.
  function automatic logic [GID_W-1:0] scan_idx(input logic [GID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[GID_W-1:0];
  endfunction

  assign scan_base = (PRIO_MODE != 0) ? '0 : rr_ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && bus.req_valid_i[scan_idx(scan_base, i)]) begin
        win_found = 1'b1;
        win_id    = scan_idx(scan_base, i);
      end
    end
  end

  assign accept   = (state_q == ST_IDLE) && win_found;
  assign done     = (state_q == ST_WAIT) && bus.mem_res_valid_i;
  assign ptr_next = (int'(grant_q) == NUM_PORTS - 1) ? '0 : grant_q + GID_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_found)            state_d = ST_REQ;
      ST_REQ:  if (bus.mem_req_ready_i)  state_d = ST_WAIT;
      ST_WAIT: if (bus.mem_res_valid_i)  state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Read strobes are forced to zero so memory can tell reads from writes by wstrb alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (accept) begin
        grant_q <= win_id;
        addr_q  <= bus.req_addr_i[int'(win_id)*ADDR_W +: ADDR_W];
        wdata_q <= bus.req_wdata_i[int'(win_id)*BLK_SIZE +: BLK_SIZE];
        wstrb_q <= bus.req_rw_i[win_id] ? bus.req_wstrb_i[int'(win_id)*STRB_W +: STRB_W] : '0;
      end
      if ((PRIO_MODE == 0) && done) begin
        rr_ptr_q <= ptr_next;
      end
    end
  end

  // req_ready is gated by reset so a requester held valid through reset sees no accept.
  always_comb begin
    req_ready     = '0;
    res_valid     = '0;
    mem_req_valid = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p] = rst_ni && accept && (win_id == GID_W'(p));
      res_valid[p] = done && (grant_q == GID_W'(p));
    end
    if (state_q == ST_REQ) mem_req_valid = 1'b1;
  end

  assign bus.req_ready_o     = req_ready;
  assign bus.res_valid_o     = res_valid;
  assign bus.res_data_o      = bus.mem_rdata_i;
  assign bus.mem_req_valid_o = mem_req_valid;
  assign bus.mem_req_addr_o  = addr_q;
  assign bus.mem_req_data_o  = wdata_q;
  assign bus.mem_req_wstrb_o = wstrb_q;
  assign bus.grant_id_o      = grant_q;
  assign bus.busy_o          = (state_q != ST_IDLE);

  a_res_only_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.mem_res_valid_i |-> (state_q == ST_WAIT));

  a_onehot_pulses: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready) && $onehot0(res_valid));

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
N-port memory arbiter that generalises the two-port I/D arbiter. It sits between the cache low-side request ports and the single block-wide memory interface. Requests are latched, one transaction is outstanding at a time, and the grant is held until the memory response returns. Selection is either round-robin or fixed priority; it never drops or duplicates a request.

Parameters:
NUM_PORTS, 2, number of requester ports (>=2)
ADDR_W, 32, address width
BLK_SIZE, 128, memory data width in bits (multiple of 8)
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins
GID_W, $clog2(NUM_PORTS), grant index width (derived localparam, min 1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NUM_PORTS  per-port request valid; held until req_ready_o
req_addr_i  in  NUM_PORTS*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
req_rw_i  in  NUM_PORTS  1 = write, 0 = read
req_wdata_i  in  NUM_PORTS*BLK_SIZE  per-port write block
req_wstrb_i  in  NUM_PORTS*BLK_SIZE/8  per-port byte enables
req_ready_o  out  NUM_PORTS  one-cycle accept pulse to the winning port
res_valid_o  out  NUM_PORTS  one-cycle response pulse to the granted port
res_data_o  out  BLK_SIZE  response data, broadcast to all ports
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts the request
mem_req_addr_o  out  ADDR_W  latched address
mem_req_data_o  out  BLK_SIZE  latched write data
mem_req_wstrb_o  out  BLK_SIZE/8  latched strobes; all zero for reads
mem_res_valid_i  in  1  memory response / write ack
mem_rdata_i  in  BLK_SIZE  memory read data
grant_id_o  out  GID_W  index of the current or last granted port
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, rr_ptr=0, grant=0, latched addr/data/strobe=0. All outputs 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any req_valid_i is set, the winner is chosen combinationally.
  - req_ready_o[winner]=1 for that cycle.
  - addr, rw, wdata and wstrb are latched (wstrb forced to 0 if rw=0); grant is set to the winner.
  - Next state is REQ.
  - If no request is valid, stay in IDLE with no outputs active.
- REQ:
  - mem_req_valid_o=1, driven from the latched fields only.
  - On mem_req_ready_i=1, go to WAIT.
  - Otherwise hold every field stable.
- WAIT:
  - On mem_res_valid_i=1: res_valid_o[grant]=1 in the same cycle (combinational) and go to IDLE.
  - In round-robin mode, rr_ptr is updated to (grant+1) mod NUM_PORTS on the same transition.
  - Reads and writes both wait for mem_res_valid_i.
- res_data_o = mem_rdata_i at all times.
- Round-robin winner: the first valid port scanning rr_ptr, rr_ptr+1, ... with wrap-around at NUM_PORTS-1 -> 0.
- Fixed priority (PRIO_MODE=1): lowest-index valid port wins; rr_ptr is unused.
- Latency:
  - Accept in cycle 0.
  - mem_req_valid_o asserted in cycle 1.
  - With mem_req_ready_i=1 in cycle 1, the earliest res_valid_o is in cycle 2.
  - Earliest re-arbitration (next accept) is cycle 3.
- A requester may drop or change its inputs after its req_ready_o pulse; the arbiter uses only latched values.
- mem_res_valid_i outside WAIT is ignored. This is a protocol violation and is flagged by an assertion.
- At most one req_ready_o bit is set per cycle; at most one res_valid_o bit is set per cycle. Both are asserted only in the states above.
- Reset mid-transaction aborts it with no response. The memory side shares rst_ni and is reset with it.

Test Plan:
- Single port: port1 read at addr 0x100 with mem_req_ready_i=1 immediately and response 0xDEAD_BEEF in cycle 2 -> req_ready_o=2'b10 in cycle 0, mem_req_valid_o in cycle 1 with addr 0x100 and wstrb 0, res_valid_o=2'b10 and res_data_o=0xDEAD_BEEF in cycle 2.
- Round-robin, NUM_PORTS=4, all ports valid continuously -> grant order 0,1,2,3,0 and each port is served once per 4 transactions.
- Fixed priority, ports 0 and 2 valid continuously -> only port 0 is granted while it stays valid; port 2 is granted after port 0 drops.
- Backpressure: mem_req_ready_i=0 for 5 cycles -> addr, data and wstrb stay stable and mem_req_valid_o=1 throughout; accepted on cycle 6; no new req_ready_o pulse meanwhile.
- Write: port0 write with wstrb 0x000F and data 0x1234 -> mem_req_wstrb_o=0x000F and mem_req_data_o=0x1234; res_valid_o[0] on the ack.
- Reset asserted in WAIT -> all outputs go to 0 immediately; after release, the first grant goes to port 0 (rr_ptr=0).
